// File: rtl/led_pwm_fader.sv
// led_pwm_fader: PWM output stage for the status-LED pattern generator.
// Each channel's brightness ramps one step per prescaler tick toward
// full-on or full-off, following the registered target pattern. The
// current brightness is then turned into a PWM drive for the LED pads.
module led_pwm_fader #(
  parameter int N_LED     = 2,
  parameter int PWM_BITS  = 8,
  parameter int STEP_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [N_LED-1:0]          pattern,
  output logic [N_LED-1:0]          led,
  output logic                      busy,
  output logic [N_LED*PWM_BITS-1:0] level
);

  localparam logic [PWM_BITS-1:0]  LEVEL_MAX  = '1;
  localparam logic [PWM_BITS-1:0]  LEVEL_ZERO = '0;
  localparam logic [PWM_BITS-1:0]  LEVEL_ONE  = 1;
  localparam logic [STEP_LOG2-1:0] PRESC_LAST = '1;
  localparam logic [STEP_LOG2-1:0] PRESC_ONE  = 1;

  logic [N_LED-1:0]     target_q;
  logic [STEP_LOG2-1:0] presc_q, presc_d;
  logic [PWM_BITS-1:0]  pwm_q, pwm_d;
  logic [PWM_BITS-1:0]  level_q [N_LED];
  logic [PWM_BITS-1:0]  level_d [N_LED];
  logic [N_LED-1:0]     led_q, led_d;
  logic                 busy_q, busy_d;
  logic                 tick;

  // Prescaler and PWM counter next state; tick marks the last enabled cycle of a step.
  always_comb begin
    presc_d = enable ? (presc_q + PRESC_ONE) : presc_q;
    tick    = enable && (presc_q == PRESC_LAST);
    pwm_d   = pwm_q + LEVEL_ONE;
  end

  // Per-channel saturating ramp, PWM compare and busy flag, all from pre-update values.
  always_comb begin
    busy_d = 1'b0;
    led_d  = '0;
    for (int i = 0; i < N_LED; i++) begin
      level_d[i] = level_q[i];
      if (tick) begin
        if (target_q[i] && (level_q[i] != LEVEL_MAX)) begin
          level_d[i] = level_q[i] + LEVEL_ONE;
        end else if (!target_q[i] && (level_q[i] != LEVEL_ZERO)) begin
          level_d[i] = level_q[i] - LEVEL_ONE;
        end
      end
      if (level_q[i] == LEVEL_MAX) begin
        led_d[i] = 1'b1;
      end else begin
        led_d[i] = (level_q[i] > pwm_q);
      end
      if (target_q[i]) begin
        busy_d = busy_d | (level_q[i] != LEVEL_MAX);
      end else begin
        busy_d = busy_d | (level_q[i] != LEVEL_ZERO);
      end
    end
  end

  // State registers; reset clears everything immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      presc_q  <= '0;
      pwm_q    <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      for (int i = 0; i < N_LED; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      target_q <= pattern;
      presc_q  <= presc_d;
      pwm_q    <= pwm_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      for (int i = 0; i < N_LED; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

  for (genvar g = 0; g < N_LED; g++) begin : g_level_out
    assign level[g*PWM_BITS +: PWM_BITS] = level_q[g];
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed stimulus for led_pwm_fader with a behavioural
// reference model compared every cycle, plus hand-computed literal checks.
module tb_led_pwm_fader;

  localparam int NL   = 2;
  localparam int PW   = 4;
  localparam int SL   = 2;
  localparam int LMAX = (1 << PW) - 1;
  localparam int STEP = 1 << SL;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [NL-1:0]     pattern;
  logic [NL-1:0]     led;
  logic              busy;
  logic [NL*PW-1:0]  level;

  int passCount  = 0;
  int totalCount = 0;
  bit checkOn    = 0;

  int       mLevel [NL];
  bit [NL-1:0] mTarget;
  bit [NL-1:0] mLed;
  bit       mBusy;
  int       mEnCount;
  int       mCycles;
  bit       mTick;
  bit       mNextBusy;
  int       mPwmNow;

  led_pwm_fader #(.N_LED(NL), .PWM_BITS(PW), .STEP_LOG2(SL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .pattern(pattern),
    .led    (led),
    .busy   (busy),
    .level  (level)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int lvl(input int i);
    return int'(level[i*PW +: PW]);
  endfunction

  // Reference model: brightness changes once per STEP enabled cycles, duty is level/2^PW.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) mLevel[i] = 0;
      mTarget  = '0;
      mLed     = '0;
      mBusy    = 1'b0;
      mEnCount = 0;
      mCycles  = 0;
    end else begin
      mTick     = enable && (((mEnCount + 1) % STEP) == 0);
      mPwmNow   = mCycles % (LMAX + 1);
      mNextBusy = 1'b0;
      for (int i = 0; i < NL; i++) begin
        if (mTarget[i]) mNextBusy = mNextBusy | (mLevel[i] != LMAX);
        else            mNextBusy = mNextBusy | (mLevel[i] != 0);
        mLed[i] = (mLevel[i] == LMAX) || (mLevel[i] > mPwmNow);
      end
      if (mTick) begin
        for (int i = 0; i < NL; i++) begin
          if (mTarget[i]) mLevel[i] = (mLevel[i] < LMAX) ? mLevel[i] + 1 : LMAX;
          else            mLevel[i] = (mLevel[i] > 0) ? mLevel[i] - 1 : 0;
        end
      end
      mBusy   = mNextBusy;
      mTarget = pattern;
      if (enable) mEnCount++;
      mCycles++;
    end
  end

  // Every-cycle comparison of all outputs against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NL*PW-1:0] expLevel;
    if (checkOn) begin
      for (int i = 0; i < NL; i++) expLevel[i*PW +: PW] = mLevel[i][PW-1:0];
      checkOutput("cycle", int'({led, busy, level}), int'({mLed, mBusy, expLevel}));
    end
  end

  task automatic runEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NL-1:0] pat, input logic en);
    pattern = pat;
    enable  = en;
  endtask

  task automatic doReset(input logic [NL-1:0] pat, input logic en);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    applyStimulus(pat, en);
    runEdges(2);
    rst_n = 1'b1;
  endtask

  task automatic countLed0(output int hits);
    hits = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      hits += int'(led[0]);
    end
  endtask

  initial begin
    int hits;
    rst_n   = 1'b1;
    enable  = 1'b0;
    pattern = '0;
    #1;
    rst_n   = 1'b0;
    applyStimulus(NL'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    #1;
    checkOn = 1;

    // Reset held with random inputs.
    runEdges(5);
    checkOutput("rst_led", int'(led), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_level", int'(level), 0);

    // Ramp channel 0 up from reset release.
    doReset(2'b01, 1'b1);
    runEdges(3);
    checkOutput("ramp_e3", lvl(0), 0);
    runEdges(1);
    checkOutput("ramp_e4", lvl(0), 1);
    runEdges(55);
    checkOutput("ramp_e59", lvl(0), 14);
    runEdges(1);
    checkOutput("ramp_e60", lvl(0), 15);
    checkOutput("ramp_busy_e60", int'(busy), 1);
    checkOutput("ramp_lvl1", lvl(1), 0);
    runEdges(1);
    checkOutput("ramp_busy_e61", int'(busy), 0);
    countLed0(hits);
    checkOutput("full_on_duty", hits, 16);

    // Asynchronous reset mid-ramp clears without a clock edge.
    doReset(2'b01, 1'b1);
    runEdges(10);
    checkOutput("midramp_lvl", lvl(0), 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear", int'(level), 0);
    runEdges(1);
    rst_n = 1'b1;

    // Duty at frozen levels 8, 1 and 0.
    doReset(2'b01, 1'b1);
    runEdges(32);
    enable = 1'b0;
    checkOutput("duty8_lvl", lvl(0), 8);
    countLed0(hits);
    checkOutput("duty8", hits, 8);
    checkOutput("duty8_hold", lvl(0), 8);
    doReset(2'b01, 1'b1);
    runEdges(4);
    enable = 1'b0;
    countLed0(hits);
    checkOutput("duty1", hits, 1);
    doReset(2'b01, 1'b0);
    countLed0(hits);
    checkOutput("duty0", hits, 0);

    // Reversal at level 6.
    doReset(2'b01, 1'b1);
    runEdges(24);
    checkOutput("rev_peak", lvl(0), 6);
    pattern = 2'b00;
    runEdges(4);
    checkOutput("rev_e28", lvl(0), 5);
    runEdges(20);
    checkOutput("rev_e48", lvl(0), 0);
    runEdges(20);
    checkOutput("rev_nowrap", lvl(0), 0);
    checkOutput("rev_busy", int'(busy), 0);

    // Saturation and pattern change landing on a tick edge.
    doReset(2'b11, 1'b1);
    runEdges(200);
    checkOutput("sat_lvl0", lvl(0), 15);
    checkOutput("sat_lvl1", lvl(1), 15);
    checkOutput("sat_busy", int'(busy), 0);
    runEdges(3);
    pattern = 2'b10;
    runEdges(1);
    checkOutput("simul_e204", lvl(0), 15);
    runEdges(1);
    checkOutput("simul_busy", int'(busy), 1);
    runEdges(3);
    checkOutput("simul_e208", lvl(0), 14);
    checkOutput("simul_lvl1", lvl(1), 15);

    // Enable toggled every 3 cycles during a ramp.
    doReset(2'b01, 1'b1);
    for (int e = 1; e <= 24; e++) begin
      runEdges(1);
      enable = (((e / 3) % 2) == 0);
      if (e == 6)  checkOutput("gate_e6", lvl(0), 0);
      if (e == 7)  checkOutput("gate_e7", lvl(0), 1);
      if (e == 14) checkOutput("gate_e14", lvl(0), 2);
      if (e == 24) checkOutput("gate_e24", lvl(0), 3);
    end
    runEdges(20);

    checkOn = 0;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
